usb_tcm_target: RTL
===================

# usb_tcm_target

Responder for the 32-bit tristate-conduit (TCM) bus that the SoC drives toward the USB chip port. It decodes chip-select, read and write strobes and the 3-bit address, and serves an 8-word register map. The map includes a pair of mailbox FIFOs to a local stream interface. It sits at board level, or in a loopback test harness, on the far side of the bidirectional data pins, and drives data only during valid reads.

## Interface
- `DEPTH`, default 16: entries per mailbox FIFO; power of two, ≥ 2.
- `ID_VALUE`, default 32'h5553_4231: constant returned at address 0.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tcm_address` input 3: register address.
- `tcm_chipselect_n`, `tcm_read_n`, `tcm_write_n`, `tcm_reset_n` input 1: active-low bus strobes, asynchronous to `clk`.
- `tcm_data_in` input 32: pin value of the data bus.
- `tcm_data_out` output 32: read data driven onto the bus.
- `tcm_data_oe` output 1: tristate enable; the top level drives the pins when this is 1.
- `rx_data` input 32, `rx_valid` input 1, `rx_ready` output 1: local → bus mailbox (push side).
- `tx_data` output 32, `tx_valid` output 1, `tx_ready` input 1: bus → local mailbox (pop side).
- `irq` output 1: level interrupt.

## Operation
**Strobe synchronisation**
- `cs`, `rd`, `wr` and `tcm_reset_n` each pass through a 2-flop synchronizer.
- `rd_act = cs & rd`; `wr_act = cs & wr`.

**Bus state machine** (states IDLE, READ, WRITE, HOLD)
- IDLE → READ on `rd_act & !wr_act`:
  - latch the address;
  - load `tcm_data_out` with the register value;
  - pop RX_DATA if address 4 and the FIFO is not empty.
- IDLE → WRITE on `wr_act & !rd_act`: sample `tcm_data_in` and the address, then commit the write in the same cycle.
- IDLE → HOLD on `rd_act & wr_act`: protocol error; ERRCNT increments; no register effect.
- READ, WRITE and HOLD each return to IDLE when both `rd_act` and `wr_act` are 0.
- Exactly one access is performed per strobe, however long the strobe lasts.

**Register map**
- 0 ID (RO): `ID_VALUE`.
- 1 CTRL (RW): bit0 enable (0 blocks both FIFOs), bit1 irq_en; other bits read 0.
- 2 STATUS (RO):
  - bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full;
  - [15:8] rx_count, [23:16] tx_count, saturating at 255.
- 3 TX_DATA (WO): push into the tx FIFO.
  - Dropped when the FIFO is full or enable = 0.
  - A drop while enable = 1 increments ERRCNT.
- 4 RX_DATA (RO): pop the rx FIFO.
  - Returns 0 when empty; an empty read increments ERRCNT.
- 5 SCRATCH (RW): full 32 bits.
- 6 ERRCNT (RO): saturating 16-bit counter, upper bits 0; a read clears it after the value is returned.
- 7: reads 0; writes are ignored.

**Local side**
- `rx_ready = enable & !rx_full`; a push occurs when `rx_valid & rx_ready`.
- `tx_valid = enable & !tx_empty`; a pop occurs when `tx_valid & tx_ready`; `tx_data` is the FIFO head (first-word fall-through).

**Interrupt**
- `irq = irq_en & !rx_empty`.

**Soft reset**
- The synchronized `tcm_reset_n` low has the same effect as `rst`, except it is applied synchronously.

## Timing
- Pin-to-action latency is 3 clk: 2 synchronizer cycles plus 1 register cycle.
- `tcm_data_oe` rises 1 cycle after entering READ and falls in the cycle READ exits.
- `tcm_data_out` is stable for as long as `tcm_data_oe` = 1.
- The bus master must meet these minimums:
  - strobe width ≥ 5 clk;
  - address and data stable from strobe assertion to deassertion;
  - gap between strobes ≥ 3 clk.
- A simultaneous local push and bus pop on the rx FIFO are both accepted; the count is unchanged. The same applies to the tx FIFO.
- FIFO pointers are log2(DEPTH)+1 bits; full/empty is decided by comparing the MSB.
- Reset values:
  - `tcm_data_out` = 0, `tcm_data_oe` = 0, `rx_ready` = 0, `tx_valid` = 0, `irq` = 0;
  - CTRL = 0, SCRATCH = 0, ERRCNT = 0;
  - FIFOs empty, state IDLE.
- A reset during a READ drops `tcm_data_oe` immediately, because the reset is asynchronous.

## Structure
- The shared package `usb_tcm_pkg` holds:
  - the address constants (`ADDR_ID` … `ADDR_RSVD`);
  - the STATUS and CTRL bit positions;
  - the state enum `tcm_state_t`.
- Sub-module `sync_fifo`: parameterised by width and depth, with a count output; instantiated twice.

## Test plan
- **Reset:** after reset, a read of address 0 → 32'h5553_4231 with `tcm_data_oe` high only during the strobe; a read of address 2 → 32'h0000_0005.
- **Scratch:** write 0xDEADBEEF to address 5, then read it back → 0xDEADBEEF; a 20-cycle strobe produces exactly one access.
- **TX path:** with CTRL = 1, write 17 words to address 3 with `tx_ready` = 0 →
  - STATUS tx_count = 16, tx_full = 1, ERRCNT = 1;
  - then raise `tx_ready` → 16 words leave in order.
- **RX path and interrupt:** with CTRL = 3, push 0x11 then 0x22 on rx →
  - `irq` = 1;
  - two reads of address 4 return 0x11 then 0x22, after which `irq` = 0;
  - a third read returns 0 and ERRCNT = 1.
- **Protocol error and clear-on-read:** assert `tcm_read_n` and `tcm_write_n` low together →
  - no register changes and `tcm_data_oe` stays 0;
  - a read of address 6 returns 1, and the next read returns 0.
- **Soft reset:** with both FIFOs half full, pulse `tcm_reset_n` low for 4 clk → STATUS = 5 and CTRL = 0.

Source files
------------

// File: rtl/usb_tcm_pkg.sv
// usb_tcm_pkg: register map, bit positions and bus state type shared by the TCM target.
package usb_tcm_pkg;
  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_CTRL    = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_TX_DATA = 3'd3;
  localparam logic [2:0] ADDR_RX_DATA = 3'd4;
  localparam logic [2:0] ADDR_SCRATCH = 3'd5;
  localparam logic [2:0] ADDR_ERRCNT  = 3'd6;
  localparam logic [2:0] ADDR_RSVD    = 3'd7;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_CNT   = 8;
  localparam int ST_TX_CNT   = 16;
  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} tcm_state_t;
  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hff : v[7:0];
  endfunction
endpackage

// File: rtl/usb_tcm_target_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with extra-MSB pointers and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count   = wp - rp;
  assign rdata   = mem[rp[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (do_pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/usb_tcm_target.sv
// usb_tcm_target: TCM bus responder with an 8-word register map and two mailbox FIFOs.
module usb_tcm_target
  import usb_tcm_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] ID_VALUE = 32'h5553_4231
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  tcm_address,
  input  logic        tcm_chipselect_n,
  input  logic        tcm_read_n,
  input  logic        tcm_write_n,
  input  logic        tcm_reset_n,
  input  logic [31:0] tcm_data_in,
  output logic [31:0] tcm_data_out,
  output logic        tcm_data_oe,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  tcm_state_t state, next;
  logic [1:0] cs_s, rd_s, wr_s, rn_s;
  logic srst, rd_act, wr_act, do_rd, do_wr, do_hold, err;
  logic enable, irq_en, rx_empty, rx_full, tx_empty, tx_full, rx_pop, tx_push;
  logic [31:0] scratch, rd_val, status, ctrl_val, rx_head;
  logic [15:0] errcnt;
  logic [CW-1:0] rx_count, tx_count;
  assign srst     = ~rn_s[1];
  assign rd_act   = cs_s[1] & rd_s[1];
  assign wr_act   = cs_s[1] & wr_s[1];
  assign rx_ready = enable & ~rx_full;
  assign tx_valid = enable & ~tx_empty;
  assign irq      = irq_en & ~rx_empty;
  assign rx_pop   = do_rd && tcm_address == ADDR_RX_DATA && !rx_empty;
  assign tx_push  = do_wr && tcm_address == ADDR_TX_DATA && enable;
  assign err      = do_hold | (tx_push & tx_full) | (do_rd && tcm_address == ADDR_RX_DATA && rx_empty);
  // strobes are held inverted so that every synchronizer resets to "inactive"
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs_s <= '0;
      rd_s <= '0;
      wr_s <= '0;
      rn_s <= '1;
    end else begin
      cs_s <= {cs_s[0], ~tcm_chipselect_n};
      rd_s <= {rd_s[0], ~tcm_read_n};
      wr_s <= {wr_s[0], ~tcm_write_n};
      rn_s <= {rn_s[0], tcm_reset_n};
    end
  always_comb begin
    next    = (state == IDLE) ? (rd_act & wr_act ? HOLD : rd_act ? READ : wr_act ? WRITE : IDLE)
                              : ((rd_act | wr_act) ? state : IDLE);
    do_rd   = state == IDLE && next == READ;
    do_wr   = state == IDLE && next == WRITE;
    do_hold = state == IDLE && next == HOLD;
  end
  always_comb begin
    status = '0;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_CNT +: 8] = sat8(32'(rx_count));
    status[ST_TX_CNT +: 8] = sat8(32'(tx_count));
    ctrl_val = '0;
    ctrl_val[CTRL_EN]     = enable;
    ctrl_val[CTRL_IRQ_EN] = irq_en;
  end
  always_comb begin
    rd_val = '0;
    case (tcm_address)
      ADDR_ID:                 rd_val = ID_VALUE;
      ADDR_CTRL:               rd_val = ctrl_val;
      ADDR_STATUS:             rd_val = status;
      ADDR_RX_DATA:            rd_val = rx_empty ? '0 : rx_head;
      ADDR_SCRATCH:            rd_val = scratch;
      ADDR_ERRCNT:             rd_val = {16'h0, errcnt};
      ADDR_TX_DATA, ADDR_RSVD: rd_val = '0;
    endcase
  end
  // the soft reset mirrors rst but only takes effect on a clock edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      tcm_data_out <= '0;
      tcm_data_oe  <= 1'b0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      scratch      <= '0;
      errcnt       <= '0;
    end else if (srst) begin
      state        <= IDLE;
      tcm_data_out <= '0;
      tcm_data_oe  <= 1'b0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      scratch      <= '0;
      errcnt       <= '0;
    end else begin
      state       <= next;
      tcm_data_oe <= state == READ && next == READ;
      if (do_rd) tcm_data_out <= rd_val;
      if (do_wr && tcm_address == ADDR_CTRL) begin
        enable <= tcm_data_in[CTRL_EN];
        irq_en <= tcm_data_in[CTRL_IRQ_EN];
      end
      if (do_wr && tcm_address == ADDR_SCRATCH) scratch <= tcm_data_in;
      errcnt <= (do_rd && tcm_address == ADDR_ERRCNT) ? '0
              : (err && errcnt != 16'hffff) ? errcnt + 16'd1 : errcnt;
    end
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .clr(srst),
    .push(rx_valid & rx_ready), .wdata(rx_data), .pop(rx_pop),
    .rdata(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .clr(srst),
    .push(tx_push), .wdata(tcm_data_in), .pop(tx_valid & tx_ready),
    .rdata(tx_data), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );
endmodule
